// File: rtl/riscv_ppreg_pkg.sv
// riscv_ppreg_pkg
// Shared types for the elastic inter-stage pipeline registers.
// Contents:
//   mw_payload_t  - packed memory/writeback stage payload
//   MW_PAYLOAD_W  - width of mw_payload_t, used as DATA_W for the MW boundary
//   PPREG_COUNT_W - width of the occupancy counter (holds 0..2)
package riscv_ppreg_pkg;

  // Memory -> writeback payload, packed most significant field first.
  typedef struct packed {
    logic [63:0] pcplus4;
    logic [63:0] aluresult;
    logic [63:0] uimm;
    logic [63:0] memload;
    logic [4:0]  rdaddr;
    logic [1:0]  resultsrc;
    logic        regw;
  } mw_payload_t;

  localparam int unsigned MW_PAYLOAD_W  = $bits(mw_payload_t);
  localparam int unsigned PPREG_COUNT_W = 2;

endpackage

// File: rtl/riscv_ppreg_skid.sv
// riscv_ppreg_skid
// Two-entry elastic pipeline register for a stage boundary. The main entry
// always drives the downstream side. The skid entry catches the one word that
// upstream may send while downstream stalls, which lets upstream ready be a
// pure register with no combinational path from downstream ready.
// Ports:
//   i_riscv_ppreg_clk    - clock, rising edge
//   i_riscv_ppreg_rst_n  - asynchronous active-low reset
//   i_riscv_ppreg_flush  - synchronous squash of held and incoming words
//   i_riscv_ppreg_valid  - upstream valid
//   o_riscv_ppreg_ready  - upstream ready (registered)
//   i_riscv_ppreg_data   - upstream payload
//   o_riscv_ppreg_valid  - downstream valid
//   i_riscv_ppreg_ready  - downstream ready
//   o_riscv_ppreg_data   - downstream payload (main entry only)
//   o_riscv_ppreg_count  - occupancy 0..2
module riscv_ppreg_skid
  import riscv_ppreg_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter bit          FLUSH_ZERO = 1'b1
) (
  input  logic                     i_riscv_ppreg_clk,
  input  logic                     i_riscv_ppreg_rst_n,
  input  logic                     i_riscv_ppreg_flush,
  input  logic                     i_riscv_ppreg_valid,
  output logic                     o_riscv_ppreg_ready,
  input  logic [DATA_W-1:0]        i_riscv_ppreg_data,
  output logic                     o_riscv_ppreg_valid,
  input  logic                     i_riscv_ppreg_ready,
  output logic [DATA_W-1:0]        o_riscv_ppreg_data,
  output logic [PPREG_COUNT_W-1:0] o_riscv_ppreg_count
);

  logic                     main_valid_r;
  logic [DATA_W-1:0]        main_data_r;
  logic                     skid_valid_r;
  logic [DATA_W-1:0]        skid_data_r;
  logic                     ready_r;
  logic [PPREG_COUNT_W-1:0] count_r;

  logic                     main_valid_s;
  logic [DATA_W-1:0]        main_data_s;
  logic                     skid_valid_s;
  logic [DATA_W-1:0]        skid_data_s;
  logic                     in_fire_s;
  logic                     out_fire_s;

  assign in_fire_s  = i_riscv_ppreg_valid & ready_r;
  assign out_fire_s = main_valid_r & i_riscv_ppreg_ready;

  // Next-state for both entries; flush overrides every other update.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    if (i_riscv_ppreg_flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
      if (FLUSH_ZERO) begin
        main_data_s = {DATA_W{1'b0}};
        skid_data_s = {DATA_W{1'b0}};
      end else begin
        main_data_s = main_data_r;
        skid_data_s = skid_data_r;
      end
    end else if (!main_valid_r) begin
      // Skid is never occupied while main is empty.
      if (in_fire_s) begin
        main_valid_s = 1'b1;
        main_data_s  = i_riscv_ppreg_data;
      end else begin
        main_valid_s = 1'b0;
      end
    end else if (out_fire_s) begin
      if (skid_valid_r) begin
        // Ready was low, so no new word can arrive this cycle.
        main_data_s  = skid_data_r;
        skid_valid_s = 1'b0;
      end else if (in_fire_s) begin
        main_data_s  = i_riscv_ppreg_data;
      end else begin
        main_valid_s = 1'b0;
      end
    end else begin
      // Downstream stalled: an accepted word parks in the skid entry.
      if (in_fire_s) begin
        skid_valid_s = 1'b1;
        skid_data_s  = i_riscv_ppreg_data;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
  end

  // Main entry register.
  always_ff @(posedge i_riscv_ppreg_clk or negedge i_riscv_ppreg_rst_n) begin
    if (!i_riscv_ppreg_rst_n) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {DATA_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
    end
  end

  // Skid entry register.
  always_ff @(posedge i_riscv_ppreg_clk or negedge i_riscv_ppreg_rst_n) begin
    if (!i_riscv_ppreg_rst_n) begin
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_W{1'b0}};
    end else begin
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
    end
  end

  // Registered ready and occupancy, derived from the next entry state.
  always_ff @(posedge i_riscv_ppreg_clk or negedge i_riscv_ppreg_rst_n) begin
    if (!i_riscv_ppreg_rst_n) begin
      ready_r <= 1'b1;
      count_r <= {PPREG_COUNT_W{1'b0}};
    end else begin
      ready_r <= ~skid_valid_s;
      count_r <= {1'b0, main_valid_s} + {1'b0, skid_valid_s};
    end
  end

  assign o_riscv_ppreg_ready = ready_r;
  assign o_riscv_ppreg_valid = main_valid_r;
  assign o_riscv_ppreg_data  = main_data_r;
  assign o_riscv_ppreg_count = count_r;

endmodule
